// File: rtl/hpu_pkg.sv
// Shared HPU types: checkpoints, recovery requests and decoded ALU instructions.
package hpu_pkg;

  localparam int CKPT_W         = 4;
  localparam int ALU_IQ_INDEX   = 3;
  localparam int ALU_DISP_DEPTH = 4;

  typedef logic [CKPT_W-1:0] ckpt_t;

  typedef struct packed {
    logic  en;
    ckpt_t ckpt;
  } update_ckpt_t;

  typedef struct packed {
    ckpt_t       ckpt;
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [15:0] opnd;
  } alu_inst_t;

  // An instruction is wrong-path if its checkpoint lies in the circular window
  // starting at the recovered checkpoint and ending at the current prefetch one.
  function automatic logic chk_ckpt(ckpt_t ent, ckpt_t rcov, ckpt_t cur);
    ckpt_t d_ent;
    ckpt_t d_cur;
    d_ent = ent - rcov;
    d_cur = cur - rcov;
    return d_ent <= d_cur;
  endfunction

endpackage

// File: rtl/hpu_alu_dispatch_sel.sv
// Picks the target ALU for a valid head: most free IQ space wins, tie pointer breaks ties.
module hpu_alu_dispatch_sel
  import hpu_pkg::*;
(
  input  logic                  head_vld,
  input  logic [ALU_IQ_INDEX:0] left0,
  input  logic [ALU_IQ_INDEX:0] left1,
  input  logic                  rdy0,
  input  logic                  rdy1,
  input  logic                  tie_ptr,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  tie_used
);

  logic tie;
  logic pref1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    tie    = (left0 == left1);
    pref1  = tie ? tie_ptr : (left1 > left0);
    if (head_vld) begin
      if (pref1) begin
        if (rdy1)      grant1 = 1'b1;
        else if (rdy0) grant0 = 1'b1;
      end else begin
        if (rdy0)      grant0 = 1'b1;
        else if (rdy1) grant1 = 1'b1;
      end
    end
    tie_used = tie && (grant0 || grant1);
  end

endmodule

// File: rtl/hpu_alu_dispatch.sv
// In-order skid FIFO between decode and the two ALU pipes, with flush and
// checkpoint-recovery squashing of buffered instructions.
module hpu_alu_dispatch
  import hpu_pkg::*;
#(
  parameter int DEPTH    = ALU_DISP_DEPTH,
  parameter bit TIE_INIT = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ctrl__inst_flush_en_i,
  input  update_ckpt_t             id__ckpt_rcov_i,
  input  ckpt_t                    id__prefet_ckpt_i,
  input  alu_inst_t                id_disp__inst_i,
  input  logic                     id_disp__inst_vld_i,
  output logic                     disp_id__inst_rdy_o,
  input  logic [ALU_IQ_INDEX:0]    alu0_disp__left_size_i,
  input  logic                     alu0_disp__inst_rdy_i,
  output alu_inst_t                disp_alu0__inst_o,
  output logic                     disp_alu0__inst_vld_o,
  input  logic [ALU_IQ_INDEX:0]    alu1_disp__left_size_i,
  input  logic                     alu1_disp__inst_rdy_i,
  output alu_inst_t                disp_alu1__inst_o,
  output logic                     disp_alu1__inst_vld_o,
  output logic [$clog2(DEPTH):0]   disp_id__buf_cnt_o
);

  localparam int PW = $clog2(DEPTH);

  alu_inst_t        mem_reg [DEPTH];
  logic [DEPTH-1:0] vld_reg, vld_next;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]      cnt_reg;
  logic             tie_reg;

  logic             flush, head_alloc, head_kill, head_live;
  logic             grant0, grant1, tie_used;
  logic             push, push_live, pop;
  logic [DEPTH-1:0] kill_vec;
  alu_inst_t        head_inst;

  assign flush = ctrl__inst_flush_en_i;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
    assign kill_vec[gi] = id__ckpt_rcov_i.en &&
                          chk_ckpt(mem_reg[gi].ckpt, id__ckpt_rcov_i.ckpt, id__prefet_ckpt_i);
  end

  assign head_alloc = (cnt_reg != '0);
  assign head_inst  = mem_reg[rd_ptr_reg];
  assign head_kill  = kill_vec[rd_ptr_reg];
  assign head_live  = head_alloc && vld_reg[rd_ptr_reg] && !head_kill && !flush;

  hpu_alu_dispatch_sel u_sel (
    .head_vld (head_live),
    .left0    (alu0_disp__left_size_i),
    .left1    (alu1_disp__left_size_i),
    .rdy0     (alu0_disp__inst_rdy_i),
    .rdy1     (alu1_disp__inst_rdy_i),
    .tie_ptr  (tie_reg),
    .grant0   (grant0),
    .grant1   (grant1),
    .tie_used (tie_used)
  );

  assign disp_id__inst_rdy_o   = (cnt_reg != (PW+1)'(DEPTH)) && !flush;
  assign push                  = id_disp__inst_vld_i && disp_id__inst_rdy_o;
  assign push_live             = !(id__ckpt_rcov_i.en &&
                                   chk_ckpt(id_disp__inst_i.ckpt, id__ckpt_rcov_i.ckpt, id__prefet_ckpt_i));
  // A squashed head (bubble) retires without issuing; a live head needs a grant.
  assign pop                   = !flush && head_alloc && (!vld_reg[rd_ptr_reg] || grant0 || grant1);

  assign disp_alu0__inst_o     = head_inst;
  assign disp_alu1__inst_o     = head_inst;
  assign disp_alu0__inst_vld_o = grant0;
  assign disp_alu1__inst_vld_o = grant1;

  always_comb begin
    vld_next = vld_reg & ~kill_vec;
    if (pop)  vld_next[rd_ptr_reg] = 1'b0;
    if (push) vld_next[wr_ptr_reg] = push_live;
  end

  always_comb begin
    disp_id__buf_cnt_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      disp_id__buf_cnt_o = disp_id__buf_cnt_o + (PW+1)'(vld_reg[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      vld_reg    <= '0;
      tie_reg    <= TIE_INIT;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      vld_reg    <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= id_disp__inst_i;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (tie_used) tie_reg    <= ~tie_reg;
      cnt_reg <= cnt_reg + (PW+1)'(push) - (PW+1)'(pop);
      vld_reg <= vld_next;
    end
  end

endmodule
